// File: rtl/modport_alu_pkg.sv
// modport_alu_pkg: opcode encoding and default datapath width shared by the ALU files.
`default_nettype none

package modport_alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRA = 3'b110,
        OP_DIV = 3'b111
    } alu_op_e;

endpackage : modport_alu_pkg

`default_nettype wire

// File: rtl/modport_alu_if.sv
// modport_alu_if: operand/opcode inputs and registered result/error outputs of the ALU.
`default_nettype none

interface modport_alu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] Result;
    logic             Error;

    modport master (
        output A,
        output B,
        output opcode,
        input  Result,
        input  Error
    );

    modport slave (
        input  A,
        input  B,
        input  opcode,
        output Result,
        output Error
    );
endinterface : modport_alu_if

`default_nettype wire

// File: rtl/modport_alu_core.sv
// modport_alu_core: purely combinational ALU function, (A, B, opcode) -> (res, err).
`default_nettype none

module modport_alu_core
    import modport_alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [WIDTH-1:0] b_i,
    input  wire logic [2:0]       opcode_i,
    output logic      [WIDTH-1:0] res_o,
    output logic                  err_o
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [4:0]       shamt;
    alu_op_e          op;

    assign sum   = a_i + b_i;
    assign diff  = a_i - b_i;
    assign shamt = b_i[4:0];
    assign op    = alu_op_e'(opcode_i);

    always_comb begin
        res_o = '0;
        err_o = 1'b0;
        unique case (op)
            OP_ADD: begin
                res_o = sum;
                err_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                res_o = diff;
                err_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_XOR: res_o = a_i ^ b_i;
            OP_SLL: res_o = a_i << shamt;
            OP_SRA: res_o = $signed(a_i) >>> shamt;
            OP_DIV: begin
                // The two undefined quotients are trapped before the divider sees them.
                if (b_i == '0) begin
                    res_o = '0;
                    err_o = 1'b1;
                end else if ((a_i == MIN_INT) && (b_i == '1)) begin
                    res_o = MIN_INT;
                    err_o = 1'b1;
                end else begin
                    res_o = $signed(a_i) / $signed(b_i);
                end
            end
            default: begin
                res_o = '0;
                err_o = 1'b0;
            end
        endcase
    end

endmodule : modport_alu_core

`default_nettype wire

// File: rtl/modport_alu.sv
// modport_alu: single-cycle registered ALU; result and error flag register together.
`default_nettype none

module modport_alu
    import modport_alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  wire logic    clk,
    input  wire logic    rst,
    modport_alu_if.slave bus
);

    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             error_d;
    logic             error_q;

    modport_alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (bus.A),
        .b_i      (bus.B),
        .opcode_i (bus.opcode),
        .res_o    (result_d),
        .err_o    (error_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign bus.Result = result_q;
    assign bus.Error  = error_q;

endmodule : modport_alu

`default_nettype wire

// File: tb/tb_modport_alu.sv
// tb_modport_alu: directed table-driven checks of the registered ALU plus reset/back-to-back sequences.
`default_nettype none

module tb_modport_alu;
    import modport_alu_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_e     op;
        logic [31:0] res;
        logic        err;
    } vec_t;

    localparam int NVEC = 17;

    logic clk;
    logic rst;
    int   tests;
    int   failed;
    vec_t vecs [NVEC];

    modport_alu_if #(.WIDTH(32)) bus ();

    modport_alu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] exp_r, input logic exp_e);
        tests++;
        if (bus.Result !== exp_r || bus.Error !== exp_e) begin
            failed++;
            $display("FAIL %s: got Result=%h Error=%b, expected Result=%h Error=%b",
                     name, bus.Result, bus.Error, exp_r, exp_e);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input alu_op_e op);
        @(negedge clk);
        bus.A      = a;
        bus.B      = b;
        bus.opcode = op;
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests  = 0;
        failed = 0;

        vecs[0]  = '{32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 1'b1};
        vecs[1]  = '{32'hFFFF_FFFB, 32'h0000_0003, OP_ADD, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{32'd10,        32'd20,        OP_SUB, 32'hFFFF_FFF6, 1'b0};
        vecs[3]  = '{32'h8000_0000, 32'h0000_0001, OP_SUB, 32'h7FFF_FFFF, 1'b1};
        vecs[4]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_AND, 32'h00F0_00F0, 1'b0};
        vecs[5]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_OR,  32'hFFF0_FFF0, 1'b0};
        vecs[6]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_XOR, 32'hFF00_FF00, 1'b0};
        vecs[7]  = '{32'h8000_0001, 32'd4,         OP_SLL, 32'h0000_0010, 1'b0};
        vecs[8]  = '{32'h8000_0001, 32'd4,         OP_SRA, 32'hF800_0000, 1'b0};
        vecs[9]  = '{32'h8000_0001, 32'h0000_0021, OP_SLL, 32'h0000_0002, 1'b0};
        vecs[10] = '{32'h8000_0001, 32'h0000_0021, OP_SRA, 32'hC000_0000, 1'b0};
        vecs[11] = '{32'hFFFF_FFF9, 32'd2,         OP_DIV, 32'hFFFF_FFFD, 1'b0};
        vecs[12] = '{32'd9,         32'd0,         OP_DIV, 32'h0000_0000, 1'b1};
        vecs[13] = '{32'h8000_0000, 32'hFFFF_FFFF, OP_DIV, 32'h8000_0000, 1'b1};
        vecs[14] = '{32'd100,       32'd7,         OP_DIV, 32'h0000_000E, 1'b0};
        vecs[15] = '{32'h4000_0000, 32'h4000_0000, OP_ADD, 32'h8000_0000, 1'b1};
        vecs[16] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, OP_SUB, 32'h8000_0000, 1'b1};

        // Reset held for two edges with a live ADD on the inputs.
        rst        = 1'b1;
        bus.A      = 32'd5;
        bus.B      = 32'd3;
        bus.opcode = OP_ADD;
        sample();
        check("reset_edge1", 32'h0, 1'b0);
        sample();
        check("reset_edge2", 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        sample();
        check("first_after_reset", 32'd8, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op);
            sample();
            check($sformatf("vec%0d_op%0d", i, vecs[i].op), vecs[i].res, vecs[i].err);
        end

        // Back-to-back: ADD, DIV by zero, AND, one op per cycle.
        drive(32'd1, 32'd2, OP_ADD);
        sample();
        check("b2b_add", 32'd3, 1'b0);
        drive(32'd9, 32'd0, OP_DIV);
        #1;
        check("b2b_hold_before_div", 32'd3, 1'b0);
        sample();
        check("b2b_div0", 32'd0, 1'b1);
        drive(32'hFF, 32'h0F, OP_AND);
        #1;
        check("b2b_hold_before_and", 32'd0, 1'b1);
        sample();
        check("b2b_and", 32'h0F, 1'b0);

        // Reset asserted during the DIV-by-zero cycle must swallow its error.
        drive(32'd1, 32'd1, OP_ADD);
        sample();
        check("rst_seq_add", 32'd2, 1'b0);
        drive(32'd9, 32'd0, OP_DIV);
        rst = 1'b1;
        sample();
        check("rst_seq_div0_discarded", 32'd0, 1'b0);
        drive(32'hFF, 32'h0F, OP_AND);
        rst = 1'b0;
        sample();
        check("rst_seq_and", 32'h0F, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_modport_alu

`default_nettype wire
